apb4_req_bridge: RTL and testbench
==================================

// Module: apb4_req_bridge
//
// PURPOSE
//   Synthesizable APB4 requester: converts a valid/ready request channel into single
//   APB4 transfers and returns each result on a valid/ready response channel.
//   Sits directly upstream of the APB4 slave cpuif and drives the master modport pins
//   of an apb4_intf instance.
//   One outstanding transfer at a time; a programmable watchdog terminates a hung ACCESS phase.
//
// PARAMETERS
//   DATA_WIDTH      32   PWDATA/PRDATA width; multiple of 8
//   ADDR_WIDTH      32   PADDR width
//   TIMEOUT_CYCLES  256  max ACCESS cycles waiting for PREADY; 0 = watchdog disabled
//
// PORTS
//   clk          in   1             clock, all state on rising edge
//   arst_n       in   1             reset, asynchronous, active-low
//   req_valid    in   1             request present
//   req_ready    out  1             request accepted when req_valid & req_ready
//   req_write    in   1             1 = write, 0 = read
//   req_addr     in   ADDR_WIDTH    byte address
//   req_wdata    in   DATA_WIDTH    write data
//   req_wstrb    in   DATA_WIDTH/8  write byte strobes
//   req_prot     in   3             PPROT value
//   rsp_valid    out  1             response present
//   rsp_ready    in   1             response consumed when rsp_valid & rsp_ready
//   rsp_rdata    out  DATA_WIDTH    read data; 0 for writes and on timeout
//   rsp_err      out  1             PSLVERR sampled, or timeout
//   rsp_timeout  out  1             watchdog fired
//   m_psel, m_penable, m_pwrite  out 1;  m_pprot out 3;  m_paddr out ADDR_WIDTH;
//   m_pwdata out DATA_WIDTH;  m_pstrb out DATA_WIDTH/8   APB4 command pins
//   m_prdata in DATA_WIDTH;  m_pready in 1;  m_pslverr in 1   APB4 response pins
//
// BEHAVIOUR
//   - Reset (arst_n=0, async): state IDLE; every output 0 except req_ready=1; watchdog count 0.
//     Reset mid-transfer drops PSEL/PENABLE immediately; the transfer is lost, no response.
//   - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs registered or decoded from state.
//   - IDLE: req_ready=1. On req_valid, register command into m_* pins, go SETUP.
//   - SETUP (exactly 1 cycle): psel=1, penable=0. Go ACCESS.
//   - ACCESS: psel=1, penable=1. Each cycle with m_pready=1: capture rsp_rdata
//     (m_prdata on reads, 0 on writes) and rsp_err=m_pslverr, rsp_timeout=0, go RESP.
//   - Watchdog counts ACCESS cycles with pready=0. If count reaches TIMEOUT_CYCLES
//     (non-zero): rsp_rdata=0, rsp_err=1, rsp_timeout=1, go RESP. pready on that same
//     cycle wins over timeout.
//   - RESP: psel=0, penable=0, rsp_valid=1, rsp_* stable until rsp_ready=1, then go IDLE.
//     Response is held indefinitely under backpressure; no new request is accepted meanwhile.
//   - m_paddr, m_pwrite, m_pprot, m_pwdata, m_pstrb are stable from SETUP through ACCESS.
//     They hold their last value while idle.
//   - Reads drive m_pstrb=0 and m_pwdata=0; writes pass req_wstrb and req_wdata unchanged.
//   - Latency: with req accepted on edge N and pready=1 in the first ACCESS cycle,
//     SETUP is cycle N+1, ACCESS is N+2, rsp_valid is seen in N+3.
//     Minimum period is 4 cycles per transfer when rsp_ready is tied high.
//   - Watchdog counter is ceil(log2(TIMEOUT_CYCLES+1)) bits, saturating, and cleared on
//     SETUP entry. The timeout path abandons the APB transfer; it is a guard, not
//     protocol-compliant.
//
// TESTING
//   1. Write 0x10 <- 0xDEADBEEF, strb 0xF, pready same cycle
//      -> SETUP/ACCESS pins correct; rsp_valid 3 cycles after accept; rsp_err=0, rdata=0.
//   2. Read 0x24, slave inserts 5 wait states, prdata=0x12345678
//      -> penable held 6 cycles with pins stable; rsp_rdata=0x12345678, pstrb=0 during transfer.
//   3. Read with pslverr=1 on the ready cycle -> rsp_err=1, rsp_timeout=0.
//   4. TIMEOUT_CYCLES=8, pready held 0
//      -> psel drops after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rdata=0.
//   5. rsp_ready=0 for 10 cycles with req_valid=1
//      -> rsp stable, req_ready=0 throughout; next request starts SETUP the cycle after the
//      rsp handshake.
//   6. Assert arst_n=0 during ACCESS -> psel/penable/rsp_valid are 0 without a clock edge;
//      after release, a read to 0x0 completes normally.

Source files
------------

// File: rtl/apb4_req_bridge.sv
// APB4 requester: one valid/ready request becomes one APB4 transfer, whose result
// comes back on a valid/ready response channel. A watchdog bounds the ACCESS phase.
module apb4_req_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    arst_n,
   // request channel
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   input  logic [2:0]              req_prot,
   // response channel
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   // APB4 master pins
   output logic                    m_psel,
   output logic                    m_penable,
   output logic                    m_pwrite,
   output logic [2:0]              m_pprot,
   output logic [ADDR_WIDTH-1:0]   m_paddr,
   output logic [DATA_WIDTH-1:0]   m_pwdata,
   output logic [DATA_WIDTH/8-1:0] m_pstrb,
   input  logic [DATA_WIDTH-1:0]   m_prdata,
   input  logic                    m_pready,
   input  logic                    m_pslverr
);

   localparam int STRB_W = DATA_WIDTH / 8;
   // One spare bit lets the count represent TIMEOUT_CYCLES itself; width 1 when disabled.
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   typedef struct packed {
      logic                  write;
      logic [2:0]            prot;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_W-1:0]     strb;
   } cmd_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } rsp_t;

   state_t           state;
   cmd_t             cmd;
   rsp_t             rsp;
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_inc;
   logic             wd_fire;

   // Saturating increment; fire on the wait cycle that brings the count to the limit.
   always_comb begin
      wd_inc  = (wd_cnt == {CNT_W{1'b1}}) ? wd_cnt : wd_cnt + CNT_W'(1);
      wd_fire = (TIMEOUT_CYCLES != 0) && !m_pready &&
                (wd_inc >= CNT_W'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state  <= IDLE;
         cmd    <= '0;
         rsp    <= '0;
         wd_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cmd.write <= req_write;
                  cmd.prot  <= req_prot;
                  cmd.addr  <= req_addr;
                  cmd.wdata <= req_write ? req_wdata : '0;
                  cmd.strb  <= req_write ? req_wstrb : '0;
                  wd_cnt    <= '0;
                  state     <= SETUP;
               end
            end
            SETUP: state <= ACCESS;
            ACCESS: begin
               if (m_pready) begin
                  rsp.rdata   <= cmd.write ? '0 : m_prdata;
                  rsp.err     <= m_pslverr;
                  rsp.timeout <= 1'b0;
                  state       <= RESP;
               end else begin
                  wd_cnt <= wd_inc;
                  if (wd_fire) begin
                     rsp.rdata   <= '0;
                     rsp.err     <= 1'b1;
                     rsp.timeout <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake and phase pins decode straight from the state register so an async
   // reset drops PSEL/PENABLE/rsp_valid without waiting for a clock edge.
   assign req_ready   = (state == IDLE);
   assign m_psel      = (state == SETUP) || (state == ACCESS);
   assign m_penable   = (state == ACCESS);
   assign rsp_valid   = (state == RESP);

   assign m_pwrite    = cmd.write;
   assign m_pprot     = cmd.prot;
   assign m_paddr     = cmd.addr;
   assign m_pwdata    = cmd.wdata;
   assign m_pstrb     = cmd.strb;

   assign rsp_rdata   = rsp.rdata;
   assign rsp_err     = rsp.err;
   assign rsp_timeout = rsp.timeout;

endmodule

// File: tb/tb_apb4_req_bridge.sv
// Directed bench for apb4_req_bridge: a per-cycle vector table for the basic transfers
// plus hand-written sequences for backpressure and mid-transfer reset.
module tb_apb4_req_bridge;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic [2:0]  req_prot = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        m_psel, m_penable, m_pwrite;
   logic [2:0]  m_pprot;
   logic [31:0] m_paddr, m_pwdata;
   logic [3:0]  m_pstrb;
   logic [31:0] m_prdata = '0;
   logic        m_pready = 1'b0, m_pslverr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   apb4_req_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .arst_n(arst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_pprot(m_pprot),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
   );

   typedef struct {
      logic        rv, wr;
      logic [31:0] addr, wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic        pready;
      logic [31:0] prdata;
      logic        slverr, rrdy;
      logic        e_rr, e_psel, e_pen, e_rv, e_pwrite;
      logic [31:0] e_paddr, e_pwdata;
      logic [3:0]  e_pstrb;
      logic [2:0]  e_pprot;
      logic [31:0] e_rdata;
      logic        e_err, e_to;
   } vec_t;

   vec_t vq[$];

   // expected APB command pins for subsequently added vectors
   logic [31:0] p_addr, p_wdata;
   logic        p_write;
   logic [3:0]  p_strb;
   logic [2:0]  p_prot;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic void pins(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] s, input logic [2:0] p);
      p_addr = a; p_write = w; p_wdata = d; p_strb = s; p_prot = p;
   endfunction

   function automatic void add(input logic rv, wr, input logic [31:0] addr, wdata,
                               input logic [3:0] strb, input logic [2:0] prot,
                               input logic pready, input logic [31:0] prdata,
                               input logic slverr, rrdy,
                               input logic e_rr, e_psel, e_pen, e_rv,
                               input logic [31:0] e_rdata, input logic e_err, e_to);
      vec_t v;
      v.rv = rv; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
      v.pready = pready; v.prdata = prdata; v.slverr = slverr; v.rrdy = rrdy;
      v.e_rr = e_rr; v.e_psel = e_psel; v.e_pen = e_pen; v.e_rv = e_rv;
      v.e_pwrite = p_write; v.e_paddr = p_addr; v.e_pwdata = p_wdata;
      v.e_pstrb = p_strb; v.e_pprot = p_prot;
      v.e_rdata = e_rdata; v.e_err = e_err; v.e_to = e_to;
      vq.push_back(v);
   endfunction

   task automatic set_req(input logic rv, wr, input logic [31:0] a, d,
                          input logic [3:0] s, input logic [2:0] p);
      req_valid = rv; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_prot = p;
   endtask

   task automatic set_slv(input logic rdy, input logic [31:0] rd, input logic err);
      m_pready = rdy; m_prdata = rd; m_pslverr = err;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // ---------------- vector table ----------------
      pins(32'h0, 1'b0, 32'h0, 4'h0, 3'h0);
      // write 0x10 <- DEADBEEF, pready in first ACCESS cycle (pready=1 in SETUP must be ignored)
      add(1,1,32'h10,32'hDEADBEEF,4'hF,3'h2, 0,32'h0,0,0,        1,0,0,0, 32'h0,0,0);
      pins(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'h2);
      add(0,0,0,0,0,0, 1,32'hFFFFFFFF,0,0,                        0,1,0,0, 32'h0,0,0);
      add(0,0,0,0,0,0, 1,32'hFFFFFFFF,0,0,                        0,1,1,0, 32'h0,0,0);
      add(0,0,0,0,0,0, 0,32'h0,0,1,                               0,0,0,1, 32'h0,0,0);
      // read 0x24 with 5 wait states; wdata/wstrb must be masked
      add(1,0,32'h24,32'hCAFEF00D,4'hF,3'h0, 0,32'h0,0,0,         1,0,0,0, 32'h0,0,0);
      pins(32'h24, 1'b0, 32'h0, 4'h0, 3'h0);
      add(0,0,0,0,0,0, 0,32'h11111111,0,0,                        0,1,0,0, 32'h0,0,0);
      for (int k = 0; k < 5; k++)
         add(0,0,0,0,0,0, 0,32'h11111111,0,0,                     0,1,1,0, 32'h0,0,0);
      add(0,0,0,0,0,0, 1,32'h12345678,0,0,                        0,1,1,0, 32'h0,0,0);
      add(0,0,0,0,0,0, 0,32'h0,0,1,                               0,0,0,1, 32'h12345678,0,0);
      // read 0x30 with PSLVERR on the ready cycle
      add(1,0,32'h30,32'h0,4'h0,3'h1, 0,32'h0,0,0,                1,0,0,0, 32'h12345678,0,0);
      pins(32'h30, 1'b0, 32'h0, 4'h0, 3'h1);
      add(0,0,0,0,0,0, 0,32'h0,0,0,                               0,1,0,0, 32'h12345678,0,0);
      add(0,0,0,0,0,0, 1,32'hA5A5A5A5,1,0,                        0,1,1,0, 32'h12345678,0,0);
      add(0,0,0,0,0,0, 0,32'h0,0,1,                               0,0,0,1, 32'hA5A5A5A5,1,0);
      // read 0x40, slave never ready: 8 ACCESS cycles then timeout response
      add(1,0,32'h40,32'h0,4'h0,3'h0, 0,32'h0,0,0,                1,0,0,0, 32'hA5A5A5A5,1,0);
      pins(32'h40, 1'b0, 32'h0, 4'h0, 3'h0);
      add(0,0,0,0,0,0, 0,32'hDEAD0000,0,0,                        0,1,0,0, 32'hA5A5A5A5,1,0);
      for (int k = 0; k < 8; k++)
         add(0,0,0,0,0,0, 0,32'hDEAD0000,0,0,                     0,1,1,0, 32'hA5A5A5A5,1,0);
      add(0,0,0,0,0,0, 0,32'hDEAD0000,0,1,                        0,0,0,1, 32'h0,1,1);
      add(0,0,0,0,0,0, 0,32'h0,0,0,                               1,0,0,0, 32'h0,1,1);

      // ---------------- reset state ----------------
      #3;
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst psel", 32'(m_psel), 32'd0);
      chk("rst penable", 32'(m_penable), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst paddr", m_paddr, 32'h0);
      chk("rst rsp_rdata", rsp_rdata, 32'h0);
      chk("rst rsp_err", 32'({rsp_err, rsp_timeout}), 32'd0);
      repeat (2) @(negedge clk);
      arst_n = 1'b1;

      // ---------------- table loop ----------------
      foreach (vq[i]) begin
         @(negedge clk);
         set_req(vq[i].rv, vq[i].wr, vq[i].addr, vq[i].wdata, vq[i].strb, vq[i].prot);
         set_slv(vq[i].pready, vq[i].prdata, vq[i].slverr);
         rsp_ready = vq[i].rrdy;
         chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vq[i].e_rr));
         chk($sformatf("v%0d psel", i), 32'(m_psel), 32'(vq[i].e_psel));
         chk($sformatf("v%0d penable", i), 32'(m_penable), 32'(vq[i].e_pen));
         chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vq[i].e_rv));
         chk($sformatf("v%0d pwrite", i), 32'(m_pwrite), 32'(vq[i].e_pwrite));
         chk($sformatf("v%0d paddr", i), m_paddr, vq[i].e_paddr);
         chk($sformatf("v%0d pwdata", i), m_pwdata, vq[i].e_pwdata);
         chk($sformatf("v%0d pstrb", i), 32'(m_pstrb), 32'(vq[i].e_pstrb));
         chk($sformatf("v%0d pprot", i), 32'(m_pprot), 32'(vq[i].e_pprot));
         chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vq[i].e_rdata);
         chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vq[i].e_err));
         chk($sformatf("v%0d rsp_timeout", i), 32'(rsp_timeout), 32'(vq[i].e_to));
      end

      // ---------------- response backpressure ----------------
      @(negedge clk);
      set_req(1, 1, 32'h50, 32'h00005050, 4'h3, 3'h0);
      set_slv(1, 32'h0, 0);
      rsp_ready = 1'b0;
      chk("bp idle req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      set_req(1, 0, 32'h60, 32'h0, 4'h0, 3'h0);
      chk("bp setup psel", 32'({m_psel, m_penable}), 32'b10);
      chk("bp setup paddr", m_paddr, 32'h50);
      @(negedge clk);
      chk("bp access penable", 32'({m_psel, m_penable}), 32'b11);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         set_slv(k[0], 32'hFFFFFFFF, 1);
         chk($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
         chk($sformatf("bp%0d psel", k), 32'({m_psel, m_penable}), 32'b00);
         chk($sformatf("bp%0d rsp", k), {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'h0);
         chk($sformatf("bp%0d pins", k), {m_paddr[27:0], m_pstrb}, {28'h50, 4'h3});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      chk("bp handshake rsp_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp post idle", 32'({req_ready, rsp_valid, m_psel}), 32'b100);
      @(negedge clk);
      set_req(0, 0, 32'h0, 32'h0, 4'h0, 3'h0);
      set_slv(1, 32'h60606060, 0);
      chk("bp next setup", 32'({m_psel, m_penable, m_pwrite}), 32'b100);
      chk("bp next paddr", m_paddr, 32'h60);
      chk("bp next pstrb", 32'(m_pstrb), 32'h0);
      @(negedge clk);
      chk("bp next access", 32'({m_psel, m_penable}), 32'b11);
      @(negedge clk);
      rsp_ready = 1'b1;
      chk("bp next rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp next rdata", rsp_rdata, 32'h60606060);
      @(negedge clk);
      rsp_ready = 1'b0;

      // ---------------- reset during ACCESS ----------------
      set_req(1, 0, 32'h70, 32'h0, 4'h0, 3'h5);
      set_slv(0, 32'h0, 0);
      @(negedge clk);
      set_req(0, 0, 32'h0, 32'h0, 4'h0, 3'h0);
      @(negedge clk);
      chk("ar access", 32'({m_psel, m_penable}), 32'b11);
      #2 arst_n = 1'b0;
      #1;
      chk("ar psel/penable", 32'({m_psel, m_penable}), 32'b00);
      chk("ar rsp_valid", 32'(rsp_valid), 32'd0);
      chk("ar req_ready", 32'(req_ready), 32'd1);
      chk("ar paddr", m_paddr, 32'h0);
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      set_req(1, 0, 32'h0, 32'h0, 4'h0, 3'h0);
      set_slv(1, 32'h0BADCAFE, 0);
      @(negedge clk);
      set_req(0, 0, 32'h0, 32'h0, 4'h0, 3'h0);
      chk("ar2 setup", 32'({m_psel, m_penable}), 32'b10);
      @(negedge clk);
      chk("ar2 access", 32'({m_psel, m_penable}), 32'b11);
      @(negedge clk);
      rsp_ready = 1'b1;
      chk("ar2 rsp_valid", 32'(rsp_valid), 32'd1);
      chk("ar2 rdata", rsp_rdata, 32'h0BADCAFE);
      chk("ar2 err/timeout", 32'({rsp_err, rsp_timeout}), 32'd0);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("ar2 back idle", 32'({req_ready, rsp_valid}), 32'b10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
